alu_nibble_seq: RTL and testbench
=================================

// Module: alu_nibble_seq
// PURPOSE
//  Multi-cycle sequencer that performs wide add/subtract on a single 4-bit ALU slice,
//  one nibble per clock, LSB nibble first, chaining carry/borrow between nibbles.
//  Lets the 4-bit adder/subtractor serve 4*NIBBLES-bit operands without a wide adder.
//  Sits between the operand source (register file/control) and the ALU slice.
// PARAMETERS
//  NIBBLES  4  operand width in nibbles; W = 4*NIBBLES; legal range 2..8
// PORTS
//  clk     in   1  single clock, rising edge
//  rst     in   1  reset: synchronous, active-high
//  start   in   1  request; sampled only when the block is not busy
//  op_as   in   1  0 = add (a+b+cin), 1 = subtract (a-b-cin)
//  a       in   W  operand A; latched when start is accepted
//  b       in   W  operand B; latched when start is accepted
//  cin     in   1  carry-in (add) / borrow-in (sub); latched when start is accepted
//  busy    out  1  high while nibbles are being computed
//  done    out  1  one-cycle pulse: result and flags valid
//  result  out  W  sum/difference; holds until the next accepted start
//  cf      out  1  add: final carry; sub: inverted final borrow (1 = no borrow)
//  zf      out  1  1 when result == 0 (whole word)
//  ovf     out  1  signed overflow (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, result=0, cf=0, zf=0, ovf=0, index=0.
//  - FSM: IDLE -> RUN on accepted start; RUN -> DONE after nibble NIBBLES-1;
//    DONE -> IDLE next cycle, or DONE -> RUN if start is high in DONE.
//  - Accept: start=1 in IDLE or DONE. In the accepting cycle t, latch a, b, op_as and cin;
//    set chain=cin and idx=0.
//  - RUN: busy=1 for cycles t+1..t+NIBBLES. Each cycle the slice computes
//    {c4,f} = a[idx]+b[idx]+chain (add) or a[idx]-b[idx]-chain (sub; 5-bit wrap,
//    c4 = borrow). Write result[4*idx+:4]=f, set chain=c4, idx++.
//  - DONE at cycle t+NIBBLES+1: done=1 for exactly one cycle, busy=0.
//    cf = chain (add) or ~chain (sub). zf = (result==0), evaluated on the full W-bit word.
//  - Latency: start-to-done = NIBBLES+1 cycles. Back-to-back throughput: one op per NIBBLES+1 cycles.
//  - start while busy: ignored. No queuing and no error flag. Operands stay stable.
//  - rst mid-RUN: abort immediately. All outputs return to reset values and no done is issued.
//  - result/cf/zf/ovf update only in DONE. During RUN they hold the previous op's values;
//    partial nibbles are staged in an internal register.
//  - Wrap-around: the final carry/borrow is reported via cf only. result is W bits modulo 2^W.
// CONFIGURATION
//  SEQ_OVF_EN defined: ovf = signed overflow of the W-bit op, set in DONE.
//    add: sign(a)==sign(b) && sign(res)!=sign(a); sub: sign(a)!=sign(b) && sign(res)!=sign(a).
//  SEQ_OVF_EN undefined: the ovf port is still present and tied to 0; no extra logic.
// STRUCTURE
//  - Package alu_seq_pkg: state encoding IDLE/RUN/DONE (2-bit), OP_ADD=0/OP_SUB=1,
//    NIBBLE_W=4.
//  - Sub-module alu4_slice: purely combinational 4-bit add/sub
//    (inputs: a, b, c0, as; outputs: f, c4).
//    Instantiated once here and driven by the nibble mux.
//  - This module holds the FSM, index counter, operand/carry latches and result staging.
// TESTING (NIBBLES=4)
//  1) add 0x1234+0x0FCC, cin=0 -> done at t+5, result=0x2200, cf=0, zf=0; busy high 4 cycles.
//  2) add 0xFFFF+0x0001, cin=0 -> result=0x0000, cf=1, zf=1 (carry chains through all nibbles).
//  3) sub 0x0005-0x0003, cin=0 -> result=0x0002, cf=1; sub 0x0003-0x0005 -> 0xFFFE, cf=0.
//  4) start pulsed at t+2 during op 1 -> ignored; a start held in DONE is accepted,
//     giving back-to-back done pulses 5 cycles apart.
//  5) rst asserted at t+2 -> next cycle busy=0, result=0; no done pulse follows.
//  6) SEQ_OVF_EN: add 0x7FFF+0x0001 -> result=0x8000, ovf=1;
//     sub 0x8000-0x0001 -> 0x7FFF, ovf=1. Macro undefined -> ovf stays 0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared constants for the nibble-serial add/subtract sequencer
// State encoding, operation codes, slice width and the signed-overflow helper.
package alu_seq_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Overflow from operand/result sign bits only, so it needs no wide adder.
    function automatic logic signed_ovf(input logic op, input logic sa,
                                        input logic sb, input logic sr);
        if (op == OP_ADD) begin
            return (sa == sb) && (sr != sa);
        end
        return (sa != sb) && (sr != sa);
    endfunction

endpackage

// File: rtl/alu4_slice.sv
// rtl/alu4_slice.sv - combinational 4-bit add/subtract slice with carry/borrow chaining
// c4 is the carry-out when adding and the borrow-out when subtracting.
module alu4_slice
    import alu_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                c0,
    input  logic                as,
    output logic [NIBBLE_W-1:0] f,
    output logic                c4
);

    logic [NIBBLE_W:0] w_sum;
    logic [NIBBLE_W:0] w_a_ext;
    logic [NIBBLE_W:0] w_b_ext;
    logic [NIBBLE_W:0] w_c_ext;

    assign w_a_ext = {1'b0, a};
    assign w_b_ext = {1'b0, b};
    assign w_c_ext = {{NIBBLE_W{1'b0}}, c0};

    // Subtraction wraps in 5 bits, so bit 4 set means a borrow was needed.
    always_comb begin
        w_sum = '0;
        if (as == OP_SUB) begin
            w_sum = w_a_ext - w_b_ext - w_c_ext;
        end else begin
            w_sum = w_a_ext + w_b_ext + w_c_ext;
        end
    end

    assign f  = w_sum[NIBBLE_W-1:0];
    assign c4 = w_sum[NIBBLE_W];

endmodule

// File: rtl/alu_nibble_seq.sv
// rtl/alu_nibble_seq.sv - wide add/subtract done one nibble per clock on a single 4-bit slice
// Optional signed overflow flag enabled by defining SEQ_OVF_EN; otherwise ovf is tied low.
module alu_nibble_seq
    import alu_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    op_as,
    input  logic [4*NIBBLES-1:0]    a,
    input  logic [4*NIBBLES-1:0]    b,
    input  logic                    cin,
    output logic                    busy,
    output logic                    done,
    output logic [4*NIBBLES-1:0]    result,
    output logic                    cf,
    output logic                    zf,
    output logic                    ovf
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    logic [1:0]          r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [W-1:0]        r_a;
    logic [W-1:0]        r_b;
    logic                r_op;
    logic                r_chain;
    logic [W-1:0]        r_stage;
    logic [W-1:0]        r_result;
    logic                r_cf;
    logic                r_zf;

    logic                w_accept;
    logic                w_last;
    logic [NIBBLE_W-1:0] w_a_nib;
    logic [NIBBLE_W-1:0] w_b_nib;
    logic [NIBBLE_W-1:0] w_f;
    logic                w_c4;
    logic [W-1:0]        w_word;

    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last   = (r_state == RUN) && (r_idx == LAST_IDX);

    assign w_a_nib = r_a[r_idx*NIBBLE_W +: NIBBLE_W];
    assign w_b_nib = r_b[r_idx*NIBBLE_W +: NIBBLE_W];

    alu4_slice u_slice (
        .a  (w_a_nib),
        .b  (w_b_nib),
        .c0 (r_chain),
        .as (r_op),
        .f  (w_f),
        .c4 (w_c4)
    );

    // Staged word with the current nibble merged in; on the last nibble this is the result.
    always_comb begin
        w_word = r_stage;
        w_word[r_idx*NIBBLE_W +: NIBBLE_W] = w_f;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= OP_ADD;
            r_chain  <= 1'b0;
            r_stage  <= '0;
            r_result <= '0;
            r_cf     <= 1'b0;
            r_zf     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a     <= a;
                r_b     <= b;
                r_op    <= op_as;
                r_chain <= cin;
                r_idx   <= '0;
                r_stage <= '0;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_stage <= w_word;
                    r_chain <= w_c4;
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) begin
                        r_state  <= DONE;
                        r_result <= w_word;
                        r_cf     <= (r_op == OP_SUB) ? ~w_c4 : w_c4;
                        r_zf     <= (w_word == '0);
                    end
                end
                DONE: begin
                    r_state <= w_accept ? RUN : IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef SEQ_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= signed_ovf(r_op, r_a[W-1], r_b[W-1], w_word[W-1]);
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign busy   = (r_state == RUN);
    assign done   = (r_state == DONE);
    assign result = r_result;
    assign cf     = r_cf;
    assign zf     = r_zf;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// tb/tb_alu_nibble_seq.sv - directed self-checking bench for alu_nibble_seq (NIBBLES=4)
module tb_alu_nibble_seq;

    localparam int W = 16;
`ifdef SEQ_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op_as;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cf;
    logic         zf;
    logic         ovf;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] prev_res;
    int gap;
    logic saw_done;

    alu_nibble_seq #(.NIBBLES(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_as  (op_as),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cf     (cf),
        .zf     (zf),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic op, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vc);
        start = 1'b1;
        op_as = op;
        a     = va;
        b     = vb;
        cin   = vc;
    endtask

    // Full operation: accept edge, four RUN cycles, then the DONE cycle and back to IDLE.
    task automatic run_op(input string tag, input logic op, input logic [W-1:0] va,
                          input logic [W-1:0] vb, input logic vc, input logic [W-1:0] er,
                          input logic ecf, input logic ezf, input logic eovf);
        drive(op, va, vb, vc);
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check({tag, ".busy"}, 32'(busy), 32'd1);
            check({tag, ".nodone"}, 32'(done), 32'd0);
            check({tag, ".hold"}, 32'(result), 32'(prev_res));
            step();
        end
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".busy_lo"}, 32'(busy), 32'd0);
        check({tag, ".res"}, 32'(result), 32'(er));
        check({tag, ".cf"}, 32'(cf), 32'(ecf));
        check({tag, ".zf"}, 32'(zf), 32'(ezf));
        check({tag, ".ovf"}, 32'(ovf), 32'(eovf));
        prev_res = er;
        step();
        check({tag, ".pulse"}, 32'(done), 32'd0);
        check({tag, ".keep"}, 32'(result), 32'(er));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op_as = 1'b0; a = '0; b = '0; cin = 1'b0;
        prev_res = '0;
        step();
        step();
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.res", 32'(result), 32'd0);
        check("rst.cf", 32'(cf), 32'd0);
        check("rst.zf", 32'(zf), 32'd0);
        check("rst.ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        step();

        run_op("add1", 1'b0, 16'h1234, 16'h0FCC, 1'b0, 16'h2200, 1'b0, 1'b0, 1'b0);
        run_op("addwrap", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        run_op("sub1", 1'b1, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0);
        run_op("sub2", 1'b1, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_op("addcin", 1'b0, 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
        run_op("subbin", 1'b1, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        run_op("ovfadd", 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, OVF_ON);
        run_op("ovfsub", 1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b0, OVF_ON);

        // Start pulsed mid-run is ignored; start held in DONE is accepted back-to-back.
        drive(1'b0, 16'h1234, 16'h0FCC, 1'b0);
        step();
        start = 1'b0;
        step();
        drive(1'b1, 16'hAAAA, 16'h5555, 1'b1);
        step();
        start = 1'b0;
        step();
        step();
        check("b2b.done1", 32'(done), 32'd1);
        check("b2b.res1", 32'(result), 32'h2200);
        drive(1'b0, 16'h1111, 16'h2222, 1'b0);
        step();
        start = 1'b0;
        check("b2b.rerun", 32'(busy), 32'd1);
        gap = 1;
        saw_done = 1'b0;
        while (!saw_done && gap < 20) begin
            step();
            gap++;
            if (done) saw_done = 1'b1;
        end
        check("b2b.seen", 32'(saw_done), 32'd1);
        check("b2b.gap", 32'(gap), 32'd5);
        check("b2b.res2", 32'(result), 32'h3333);
        step();

        // Reset in the middle of a run aborts it with no done pulse.
        drive(1'b0, 16'h0101, 16'h0101, 1'b0);
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.res", 32'(result), 32'd0);
        check("abort.cf", 32'(cf), 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done) saw_done = 1'b1;
            step();
        end
        check("abort.nodone", 32'(saw_done), 32'd0);
        prev_res = '0;
        run_op("post", 1'b0, 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
